next_pc_fetch: RTL
==================

// Module: next_pc_fetch
// PURPOSE
//  Fetch-side partner of the PC register: consumes the current pc, fetches the instruction over a
//  valid/ready imem interface, hands it to decode, and drives nextpc back into the PC register.
//  The PC register loads nextpc on every clock, so this block stalls fetch by driving nextpc = pc.
//  Sits between the PC register, the instruction memory and the decode stage.
// PARAMETERS
//  RESET_PC        32'h0000_0000  nextpc value driven while rst=1
//  TIMEOUT_CYCLES  16             imem response timeout; used only with FETCH_TIMEOUT_EN, must be >=2
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  rst              in   1   synchronous reset, active-high
//  pc               in   32  current PC from the PC register
//  nextpc           out  32  PC for the next cycle, combinational
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   imem accepts the request
//  imem_req_addr    out  32  fetch address = {pc[31:2],2'b00}
//  imem_resp_valid  in   1   instruction word valid (one pulse per accepted request)
//  imem_resp_data   in   32  instruction word
//  inst_valid       out  1   instruction buffered and offered to decode
//  inst_ready       in   1   decode accepts the instruction
//  inst             out  32  buffered instruction
//  inst_pc          out  32  address the buffered instruction was fetched from
//  redirect_valid   in   1   branch/jump taken; overrides sequential flow
//  redirect_target  in   32  redirect address; bits [1:0] are forced to 00
//  fetch_err        out  1   sticky imem timeout flag (always 0 without FETCH_TIMEOUT_EN)
// BEHAVIOUR
//  States: S_REQ, S_WAIT, S_HOLD, S_DRAIN. At most one imem request outstanding.
//  Reset (rst=1 on a clock edge): state->S_REQ; inst, inst_pc, fetch_err, counter <= 0.
//   While rst=1: nextpc=RESET_PC; imem_req_valid=0; inst_valid=0.
//  S_REQ: imem_req_valid=1. On imem_req_ready -> S_WAIT.
//  S_WAIT: on imem_resp_valid, latch inst<=imem_resp_data, inst_pc<=pc -> S_HOLD.
//  S_HOLD: inst_valid=1. inst/inst_pc stay stable until accepted. On inst_ready -> S_REQ.
//  S_DRAIN: discard the next imem_resp_valid -> S_REQ. imem_req_valid=0.
//  nextpc, by priority:
//   - redirect_valid: {redirect_target[31:2],2'b00}
//   - S_HOLD && inst_ready: pc + 32'd4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0)
//   - otherwise: pc (hold)
//  Latency: request issued in the reset-release cycle. With ready=1 and a 1-cycle response,
//   inst_valid is seen 2 cycles after the request. Sustained rate: 1 instr / 3 cycles.
//  Redirect (any state, non-reset) kills the in-flight instruction:
//   - S_HOLD: the instruction is dropped with no handoff, even if inst_ready=1 -> S_REQ.
//   - S_REQ without imem_req_ready -> S_REQ; the request is re-issued next cycle at the new pc.
//   - S_REQ with imem_req_ready -> S_DRAIN.
//   - S_WAIT without imem_resp_valid -> S_DRAIN.
//   - S_WAIT with imem_resp_valid -> S_REQ; the response is discarded.
//   - S_DRAIN: stays in S_DRAIN until the response arrives.
//  imem_resp_valid outside S_WAIT/S_DRAIN is ignored.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - A counter runs in S_WAIT/S_DRAIN and clears on state exit.
//   - If no response arrives within TIMEOUT_CYCLES cycles, fetch_err<=1 (sticky until rst) and
//     state -> S_REQ, re-issuing the request at the current pc.
//   - A response arriving after the timeout is treated as stray and ignored.
//  FETCH_TIMEOUT_EN undefined: no counter; fetch_err tied to 0; the block waits indefinitely.
// TESTING
//  1. rst=1 for 2 cycles, RESET_PC=0 -> nextpc=0, req_valid=0, inst_valid=0. After release,
//     req_valid=1 with addr=0.
//  2. ready=1, 1-cycle response 32'h0000_0013, inst_ready=1 -> inst=13 and inst_pc=0; nextpc=4
//     in that cycle; the next request has addr=4.
//  3. inst_ready=0 for 5 cycles in S_HOLD -> nextpc=pc and inst stable for all 5 cycles;
//     no new request issued.
//  4. redirect_valid with target 32'h0000_0103 while in S_WAIT -> nextpc=32'h100; the old
//     response is discarded; the next request has addr=32'h100.
//  5. pc=32'hFFFF_FFFC, handoff -> nextpc=0.
//  6. FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response -> fetch_err=1 after 4 cycles in S_WAIT;
//     the request is re-issued at the same pc; fetch_err stays 1 until rst.

Source files
------------

// File: rtl/next_pc_fetch.sv
// next_pc_fetch: fetches the instruction at pc over imem, buffers it for decode, and drives nextpc.
// Optional FETCH_TIMEOUT_EN adds an imem response timeout with a sticky fetch_err flag.
module next_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] nextpc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_err
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t state, state_nx;
  logic timeout;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  logic waiting;
  assign waiting = state == S_WAIT || state == S_DRAIN;
  assign timeout = waiting && !imem_resp_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt <= (waiting && state_nx == state) ? cnt + 1'b1 : '0;
      if (timeout) fetch_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT && state_nx == S_HOLD) begin
        inst <= imem_resp_data;
        inst_pc <= pc;
      end
    end
  end
  // a redirect kills whatever is in flight; an outstanding response must still be drained
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ:   state_nx = imem_req_ready ? (redirect_valid ? S_DRAIN : S_WAIT) : S_REQ;
      S_WAIT:  state_nx = imem_resp_valid ? (redirect_valid ? S_REQ : S_HOLD) :
                          timeout ? S_REQ : redirect_valid ? S_DRAIN : S_WAIT;
      S_HOLD:  state_nx = (redirect_valid || inst_ready) ? S_REQ : S_HOLD;
      default: state_nx = (imem_resp_valid || timeout) ? S_REQ : S_DRAIN;
    endcase
  end
  always_comb begin
    imem_req_valid = !rst && state == S_REQ;
    inst_valid = !rst && state == S_HOLD;
    imem_req_addr = pc & ~32'd3;
    nextpc = rst ? RESET_PC :
             redirect_valid ? (redirect_target & ~32'd3) :
             (state == S_HOLD && inst_ready) ? pc + 32'd4 : pc;
  end
endmodule
